// File: rtl/dff_pipe_elastic_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dff_pipe_elastic_if
// Purpose  : Producer/consumer valid-ready bus for the elastic register pipe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface dff_pipe_elastic_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/dff_pipe_elastic.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dff_pipe_elastic
// Purpose  : DEPTH-stage elastic register pipe with bubble collapse and flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module dff_pipe_elastic #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  dff_pipe_elastic_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // A stage can load when it is empty or everything downstream will move.
  always_comb begin : ready_chain
    logic acc;
    acc = bus.out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | ~v_q[i];
      rdy[i] = acc;
    end
  end

  always_comb begin : upstream
    up_v[0] = bus.in_valid;
    up_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v_q[i-1];
      up_d[i] = d_q[i-1];
    end
  end

  always_comb begin : next_state
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = up_v[i];
          if (up_v[i]) d_d[i] = up_d[i];
        end
      end
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RST_VAL;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

  assign bus.in_ready  = rdy[0] & ~flush;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_elastic.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_dff_pipe_elastic
// Purpose  : Directed vector table plus randomized queue-model bench.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_dff_pipe_elastic;

  localparam int WIDTH = 4;
  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;

  dff_pipe_elastic_if #(.WIDTH(WIDTH)) bus ();

  dff_pipe_elastic #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (4'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, fl, iv;
    logic [3:0] din;
    logic       ordy, chk, e_ir, e_ov;
    logic [3:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    int         t;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];

  function automatic vec_t mk(bit r, bit f, bit iv, logic [3:0] din, bit ordy,
                              bit chk, bit ir, bit ov, logic [3:0] od,
                              logic [1:0] cnt);
    vec_t x;
    x.rst = r; x.fl = f; x.iv = iv; x.din = din; x.ordy = ordy;
    x.chk = chk; x.e_ir = ir; x.e_ov = ov; x.e_od = od; x.e_cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit iv,
                       input logic [3:0] din, input bit ordy);
    rst          = r;
    flush        = f;
    bus.in_valid = iv;
    bus.in_data  = din;
    bus.out_ready = ordy;
  endtask

  initial begin
    logic [3:0] din;
    bit r, f, iv, ordy, m_ov, m_ir;
    int ecnt;

    //            r f iv din  or chk ir ov od   cnt
    vecs.push_back(mk(1,0,1,4'hF,0,0, 0,0,4'h0,0));
    vecs.push_back(mk(1,0,1,4'hF,0,1, 1,0,4'h0,0));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,0,4'h0,0));
    vecs.push_back(mk(0,0,1,4'h1,1,1, 1,0,4'h0,0));
    vecs.push_back(mk(0,0,1,4'h2,1,1, 1,0,4'h0,1));
    vecs.push_back(mk(0,0,1,4'h3,1,1, 1,0,4'h0,2));
    vecs.push_back(mk(0,0,1,4'h4,1,1, 1,1,4'h1,3));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'h2,3));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'h3,2));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'h4,1));
    vecs.push_back(mk(0,0,1,4'hA,0,1, 1,0,4'h4,0));
    vecs.push_back(mk(0,0,1,4'hB,0,1, 1,0,4'h4,1));
    vecs.push_back(mk(0,0,1,4'hC,0,1, 1,0,4'h4,2));
    vecs.push_back(mk(0,0,1,4'hD,0,1, 0,1,4'hA,3));
    vecs.push_back(mk(0,0,1,4'hD,1,1, 1,1,4'hA,3));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'hB,3));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'hC,2));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'hD,1));
    vecs.push_back(mk(0,0,1,4'h5,0,1, 1,0,4'hD,0));
    vecs.push_back(mk(0,0,0,4'h0,0,1, 1,0,4'hD,1));
    vecs.push_back(mk(0,0,1,4'h6,0,1, 1,0,4'hD,1));
    vecs.push_back(mk(0,0,0,4'h0,0,1, 1,1,4'h5,2));
    vecs.push_back(mk(0,0,0,4'h0,0,1, 1,1,4'h5,2));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'h5,2));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,1,4'h6,1));
    vecs.push_back(mk(0,0,1,4'h7,0,1, 1,0,4'h6,0));
    vecs.push_back(mk(0,0,1,4'h8,0,1, 1,0,4'h6,1));
    vecs.push_back(mk(0,0,0,4'h0,0,1, 1,0,4'h6,2));
    vecs.push_back(mk(0,1,1,4'h9,0,1, 0,1,4'h7,2));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,0,4'h7,0));
    vecs.push_back(mk(0,0,0,4'h0,1,1, 1,0,4'h7,0));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].fl, vecs[k].iv, vecs[k].din, vecs[k].ordy);
      @(negedge clk);
      if (vecs[k].chk) begin
        chk($sformatf("vec%0d in_ready", k),  {31'b0, bus.in_ready},  {31'b0, vecs[k].e_ir});
        chk($sformatf("vec%0d out_valid", k), {31'b0, bus.out_valid}, {31'b0, vecs[k].e_ov});
        chk($sformatf("vec%0d out_data", k),  {28'b0, bus.out_data},  {28'b0, vecs[k].e_od});
        chk($sformatf("vec%0d count", k),     {30'b0, count},         {30'b0, vecs[k].e_cnt});
      end
      @(posedge clk); #1;
    end

    // Fill, wiggle out_ready, then reset while words are in flight.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 4'hE, 0); @(posedge clk); #1;
    end
    drive(0, 0, 1, 4'h3, 1); @(posedge clk); #1;
    drive(0, 0, 1, 4'h4, 0); @(posedge clk); #1;
    drive(1, 0, 1, 4'hF, 1); @(posedge clk); #1;
    drive(0, 0, 0, 4'h0, 1);
    @(negedge clk);
    chk("midrst out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst out_data",  {28'b0, bus.out_data},  32'd0);
    chk("midrst count",     {30'b0, count},         32'd0);
    chk("midrst in_ready",  {31'b0, bus.in_ready},  32'd1);
    @(posedge clk); #1;

    // Random traffic against a queue of (word, accept-edge) pairs; the
    // oldest word is visible once it has aged DEPTH edges.
    ecnt = 0;
    for (int c = 0; c < 800; c++) begin
      r    = ($urandom_range(0, 59) == 0);
      f    = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      din  = 4'($urandom);
      drive(r, f, iv, din, ordy);
      @(negedge clk);
      m_ov = (q.size() > 0) && (ecnt - q[0].t >= DEPTH);
      m_ir = !f && ((q.size() < DEPTH) || ordy);
      chk("rand out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
      chk("rand in_ready",  {31'b0, bus.in_ready},  {31'b0, m_ir});
      chk("rand count",     {30'b0, count},         q.size());
      if (m_ov) chk("rand out_data", {28'b0, bus.out_data}, {28'b0, q[0].d});
      if (r) begin
        q.delete();
      end else begin
        if (m_ov && ordy) void'(q.pop_front());
        if (f) q.delete();
        else if (iv && m_ir) q.push_back('{d: din, t: ecnt});
      end
      ecnt++;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dff_pipe_elastic.md
Name: dff_pipe_elastic

Overview:
- Parametrised successor to the single 4-bit D flip-flop: a chain of DEPTH registers, each WIDTH bits wide, with per-stage valid bits and a valid/ready handshake.
- Bubbles collapse: an empty stage always accepts data, even while the output is stalled.
- Synchronous flush, synchronous reset value and occupancy count.
- Sits between producer and consumer datapaths as a retiming/latency-matching element; it is the next DUT for the DFF verification bench.

Parameters:
- WIDTH, 4, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- RST_VAL, 0, WIDTH-bit value loaded into every data register on reset.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stage valid bits.
- in_valid  in  1  producer presents in_data.
- in_ready  out  1  pipeline accepts in_data this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  output word (last stage register).
- count  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State per stage i (0 = input side, DEPTH-1 = output side): v[i] is the valid bit, d[i] is the WIDTH-bit data register.
- Reset:
  - When rst=1 at a clk edge: all v[i]=0 and all d[i]=RST_VAL.
  - After reset: out_valid=0, out_data=RST_VAL, count=0.
  - in_ready is 1 after reset (combinational; see below).
  - rst overrides flush and all handshakes. Reset mid-transfer discards all contents, with no partial state.
- Ready chain (combinational, no registered ready):
  - r[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - r[i] = r[i+1] | ~v[i].
  - in_ready = r[0] & ~flush.
- Transfers: input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
- Stage update at clk when rst=0 and flush=0, for each i with r[i]=1:
  - v[i] <= upstream valid. Upstream valid is in_valid for i=0, otherwise v[i-1].
  - d[i] <= upstream data only when upstream valid=1; otherwise d[i] holds its value (no toggling on bubbles).
  - Stages with r[i]=0 hold v and d.
- Output: out_valid=v[DEPTH-1], out_data=d[DEPTH-1], both driven directly from registers.
- Latency and throughput:
  - A word accepted at edge N appears at out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from presentation to availability, when there are no stalls.
  - Throughput is 1 word/cycle with out_ready held high.
- Stall behaviour:
  - With out_ready=0, words advance into empty downstream stages until all DEPTH stages are valid; then in_ready=0.
  - Capacity is exactly DEPTH words.
  - Full pipeline with out_ready=1: in_ready=1 in the same cycle (pass-through of ready). Simultaneous in and out handshakes keep count constant.
- Flush:
  - At clk with flush=1 (rst=0): all v[i] <= 0; d[i] hold.
  - in_ready=0 during the flush cycle, so no input handshake occurs.
  - An output handshake during the flush cycle is still a legal transfer (out_valid is unaffected until the edge).
  - count=0 on the next cycle.
- count = popcount(v), registered-derived.
- Full = (count==DEPTH); empty = (count==0).
- No data loss or duplication: every accepted word exits exactly once, in order, unless discarded by flush or rst.
- DEPTH=1 degenerates to a single-entry register slice with the same rules.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=4'hF -> out_valid=0, out_data=4'h0, count=0, in_ready=1 after release.
- Streaming: out_ready=1, send 4'h1,4'h2,4'h3,4'h4 on consecutive cycles -> out_data shows 1,2,3,4 on consecutive cycles, first word valid 3 cycles after acceptance, count steady at 3 mid-stream.
- Back-pressure: out_ready=0, offer 4'hA,4'hB,4'hC,4'hD -> A,B,C accepted, in_ready=0 while D is offered, count=3. Then out_ready=1 -> A,B,C,D exit in order, with D accepted the same cycle A leaves.
- Bubble collapse: send 4'h5, idle 1 cycle, send 4'h6 with out_ready=0 -> both packed into stages 2 and 1 (count=2, out_data=5). in_ready stays 1.
- Flush: pipeline holding 4'h7,4'h8 with out_ready=0. Assert flush 1 cycle while in_valid=1, in_data=4'h9 -> in_ready=0, next cycle count=0, out_valid=0, and 4'h9 never emerges.
- Reset mid-operation: full pipeline, out_ready toggling, rst=1 one cycle -> all contents dropped, out_data=4'h0. A scoreboard confirms no stale word emerges afterwards.
